// File: rtl/add_scheduler.sv
// ============================================================================
//  Module   : add_scheduler
//  Brief    : Two-requester 64-bit (N*W) adder built around a single N-bit
//             carry-lookahead slice, time-shared over W beats per operation.
//             Round-robin arbitration, one operation in flight, valid/ready
//             handshakes on both the request and response sides.
//  Revision : 1.0 - initial release
// ============================================================================

`default_nettype none

// ----------------------------------------------------------------------------
//  add_cla_slice : N-bit adder made of 4-bit carry-lookahead groups whose
//  group carries ripple from one group to the next.
// ----------------------------------------------------------------------------
module add_cla_slice #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int GROUPS = N / 4;

    // Carry entering each 4-bit group; index GROUPS is the slice carry-out.
    logic [GROUPS:0] group_c;

    assign group_c[0] = cin;

    generate
        for (genvar g = 0; g < GROUPS; g++) begin : g_grp
            logic [3:0] p;
            logic [3:0] gn;
            logic [4:0] c;

            assign p  = a[4*g +: 4] ^ b[4*g +: 4];
            assign gn = a[4*g +: 4] & b[4*g +: 4];

            // Flattened lookahead equations inside the group.
            assign c[0] = group_c[g];
            assign c[1] = gn[0] | (p[0] & c[0]);
            assign c[2] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1])
                        | (p[3] & p[2] & p[1] & gn[0])
                        | (p[3] & p[2] & p[1] & p[0] & c[0]);

            assign sum[4*g +: 4] = p ^ c[3:0];
            assign group_c[g+1]  = c[4];
        end
    endgenerate

    assign cout = group_c[GROUPS];

endmodule

// ----------------------------------------------------------------------------
//  add_scheduler : arbitration, operand capture and beat sequencing.
// ----------------------------------------------------------------------------
module add_scheduler #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N*W-1:0] req0_a,
    input  logic [N*W-1:0] req0_b,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N*W-1:0] req1_a,
    input  logic [N*W-1:0] req1_b,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N*W-1:0] rsp_sum,
    output logic           rsp_cout,
    output logic           rsp_id
);

    localparam int NW = N * W;
    localparam int KW = $clog2(W + 1);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic [KW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic [NW-1:0] a_q, a_d;
    logic [NW-1:0] b_q, b_d;
    logic          id_q, id_d;
    logic [NW-1:0] sum_q, sum_d;

    logic          grant_id;
    logic          accept;
    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;

    // Arbitration: a lone valid requester wins, a tie goes to the rr pointer.
    // Readies are suppressed while reset is asserted.
    always_comb begin
        grant_id   = (req0_valid & req1_valid) ? rr_q : req1_valid;
        req0_ready = ~rst & (state_q == ST_IDLE) & req0_valid & ~grant_id;
        req1_ready = ~rst & (state_q == ST_IDLE) & req1_valid &  grant_id;
        accept     = req0_ready | req1_ready;
    end

    // Select the operand slice for the current beat from the captured operands.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int s = 0; s < W; s++) begin
            if (k_q == KW'(s)) begin
                slice_a = a_q[s*N +: N];
                slice_b = b_q[s*N +: N];
            end
        end
    end

    // The only adder in the design; shared by every beat and both requesters.
    add_cla_slice #(
        .N (N)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state logic: capture on accept, one slice per RUN beat, hold in DONE.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        sum_d   = sum_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = grant_id ? req1_a : req0_a;
                    b_d     = grant_id ? req1_b : req0_b;
                    id_d    = grant_id;
                    rr_d    = ~grant_id;
                    carry_d = 1'b0;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                for (int s = 0; s < W; s++) begin
                    if (k_q == KW'(s)) begin
                        sum_d[s*N +: N] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                // k wraps back to zero on the final beat so it stays in range.
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset that aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
        end
    end

    // After the final beat the carry register holds the carry out of the top bit.
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
    assign rsp_id    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_add_scheduler.sv
// ============================================================================
//  Module   : tb_add_scheduler
//  Brief    : Self-checking bench for add_scheduler: directed corner cases,
//             arbitration order, back-pressure, mid-run reset and randomized
//             operands against a wide-arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_add_scheduler;

    localparam int N  = 16;
    localparam int W  = 4;
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [NW-1:0] req0_a, req0_b;
    logic          req1_valid, req1_ready;
    logic [NW-1:0] req1_a, req1_b;
    logic          rsp_valid, rsp_ready;
    logic [NW-1:0] rsp_sum;
    logic          rsp_cout;
    logic          rsp_id;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  rr_m;          // reference round-robin pointer
    bit  gap_on;        // check accept spacing for the next transaction
    int  last_hold;     // rsp_ready-low cycles of the previous transaction
    time last_acc;

    add_scheduler #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NW:0] got, input logic [NW:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic scramble();
        req0_a = rnd64();
        req0_b = rnd64();
        req1_a = rnd64();
        req1_b = rnd64();
    endtask

    // One complete operation, entered and left at a falling edge.
    task automatic txn(input bit v0, input bit v1,
                       input logic [NW-1:0] a0, input logic [NW-1:0] b0,
                       input logic [NW-1:0] a1, input logic [NW-1:0] b1,
                       input int hold);
        logic [NW:0] exp;
        bit          g;
        int          lat;
        rsp_ready  = (hold == 0);
        req0_valid = v0;
        req1_valid = v1;
        req0_a = a0; req0_b = b0;
        req1_a = a1; req1_b = b1;
        #1;
        g = (v0 && v1) ? rr_m : v1;
        check("req0_ready", req0_ready, v0 && !g);
        check("req1_ready", req1_ready, v1 && g);
        exp = g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        @(posedge clk);
        if (gap_on) check("accept_gap", ($time - last_acc) / 10, W + 2 + last_hold);
        last_acc = $time;
        gap_on   = 1'b1;
        rr_m     = !g;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            check("busy_readies", {req0_ready, req1_ready}, 0);
            scramble();
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, W);
        check("sum", rsp_sum, exp[NW-1:0]);
        check("cout", rsp_cout, exp[NW]);
        check("id", rsp_id, g);
        for (int h = 0; h < hold; h++) begin
            check("done_readies", {req0_ready, req1_ready}, 0);
            scramble();
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_sum", rsp_sum, exp[NW-1:0]);
            check("hold_cout_id", {rsp_cout, rsp_id}, {exp[NW], g});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("released", rsp_valid, 0);
        last_hold  = hold;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_cout_id", {rsp_cout, rsp_id}, 0);
        check("rst_readies", {req0_ready, req1_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_held_readies", {req0_ready, req1_ready}, 0);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rr_m   = 1'b0;
        gap_on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit v0, v1;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rr_m = 1'b0; gap_on = 1'b0; last_hold = 0; last_acc = 0;
        #7;
        check("init_valid", rsp_valid, 0);
        check("init_sum", rsp_sum, 0);
        check("init_cout_id", {rsp_cout, rsp_id}, 0);
        check("init_readies", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // All-ones plus one: carry through every slice and out of the top.
        txn(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, rnd64(), rnd64(), 0);
        // Carry crossing slice 0 into slice 1 only.
        txn(0, 1, rnd64(), rnd64(), 64'h0000_0000_0000_FFFF, 64'h1, 0);
        // Back-pressure for three cycles, then release.
        txn(1, 1, rnd64(), rnd64(), rnd64(), rnd64(), 3);

        // Reset in the middle of an operation (beat k=2).
        req0_valid = 1'b1;
        req0_a = rnd64(); req0_b = rnd64();
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        apply_reset();
        check("abort_valid", rsp_valid, 0);
        txn(0, 1, rnd64(), rnd64(), rnd64(), rnd64(), 0);

        // Both requesters continuously valid from reset: 0,1,0,1.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, rnd64(), rnd64(), rnd64(), rnd64(), 0);
        end

        // Valid pulses that drop before any edge must not move the pointer.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        gap_on = 1'b0;
        txn(1, 1, rnd64(), rnd64(), rnd64(), rnd64(), 0);
        txn(1, 1, rnd64(), rnd64(), rnd64(), rnd64(), 1);

        // Randomized operands, requesters and back-pressure.
        for (int i = 0; i < 12; i++) begin
            v0 = $urandom_range(0, 1);
            v1 = $urandom_range(0, 1);
            if (!v0 && !v1) v0 = 1'b1;
            txn(v0, v1, rnd64(), rnd64(), rnd64(), rnd64(), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
